// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_pkg
//  Description : Shared types and constants for the sweep sequencer.
//                sweep_state_t - controller state encoding
//                freq_q20_t    - Q20 fixed-point frequency word
//  Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCALE   = 2'd1,
        ST_DIVIDE  = 2'd2,
        ST_PUBLISH = 2'd3
    } sweep_state_t;

    typedef logic [31:0] freq_q20_t;

    // Fractional bits of the step multiplier.
    localparam int c_q16_shift = 16;
    // Dividend width of the period divider.
    localparam int c_div_width = 48;

endpackage : sweep_pkg
`default_nettype wire

// File: rtl/sweep_divider.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_divider
//  Description : Serial restoring divider, one quotient bit per clock.
//                A start pulse loads the operands; the quotient is produced
//                after c_div_width iteration cycles. done is asserted
//                combinationally during the last iteration cycle and
//                quotient is valid only while done is high. Quotients wider
//                than 32 bits, and a zero divisor, saturate to all ones.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start               - load operands and begin (wins over abort)
//                abort               - drop an in-flight division
//                dividend [47:0]     - numerator
//                divisor  [31:0]     - denominator
//                done                - last iteration, quotient valid
//                quotient [31:0]     - saturated result
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_divider
    import sweep_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [c_div_width-1:0] dividend,
    input  logic [31:0]            divisor,
    output logic                   done,
    output logic [31:0]            quotient
);

    localparam int c_cnt_w = $clog2(c_div_width);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_div_width - 1);

    logic                   run_q,  run_d;
    logic [c_cnt_w-1:0]     cnt_q,  cnt_d;
    logic [31:0]            rem_q,  rem_d;
    logic [c_div_width-1:0] quo_q,  quo_d;   // dividend bits shift out the top, quotient bits in the bottom
    logic [31:0]            dvs_q,  dvs_d;

    logic [32:0]            rem_sh;
    logic                   ge;
    logic [31:0]            rem_nx;
    logic [c_div_width-1:0] quo_nx;
    logic                   last;

    always_comb begin
        rem_sh = {rem_q, quo_q[c_div_width-1]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        // Remainder is always below the divisor, so it fits in 32 bits.
        rem_nx = ge ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
        quo_nx = {quo_q[c_div_width-2:0], ge};
        last   = run_q && (cnt_q == c_cnt_last);

        done     = last;
        quotient = ((dvs_q == '0) || (|quo_nx[c_div_width-1:32])) ? 32'hFFFF_FFFF
                                                                   : quo_nx[31:0];

        run_d = run_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;

        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (abort) begin
            run_d = 1'b0;
        end else if (run_q) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule : sweep_divider
`default_nettype wire

// File: rtl/sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_sequencer
//  Description : Exponential frequency sweep controller for the oscillator
//                bank. Every STEP_SAMPLES enabled sample ticks the Q20
//                frequency is scaled by STEP_MUL (Q16) and wraps to the start
//                frequency at UPPER_FREQ; the new sample period is computed
//                by a serial divider and published with a one-cycle pulse.
//  Macro       : SWEEP_OVERRUN_EN - adds the sticky 'overrun' output.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                sample_tick         - one pulse per output sample
//                enable              - gates sample_tick
//                restart             - return to start frequency
//                frequency [31:0]    - current frequency, Q20
//                wave_length [31:0]  - samples per period
//                wave_length_valid   - pulse when wave_length updates
//                overrun             - step lost (macro only)
//                busy                - update in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int SAMPLE_RATE  = 48000,
    parameter int FRAC_BITS    = 20,
    parameter int START_FREQ   = 55,
    parameter int UPPER_FREQ   = 1000,
    parameter int STEP_SAMPLES = 50,
    parameter int STEP_MUL     = 66191
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic        enable,
    input  logic        restart,
    output logic [31:0] frequency,
    output logic [31:0] wave_length,
    output logic        wave_length_valid,
`ifdef SWEEP_OVERRUN_EN
    output logic        overrun,
`endif
    output logic        busy
);

    localparam logic [63:0] c_start_w    = 64'(START_FREQ) << FRAC_BITS;
    localparam logic [63:0] c_upper_w    = 64'(UPPER_FREQ) << FRAC_BITS;
    localparam logic [63:0] c_dividend_w = 64'(SAMPLE_RATE) << FRAC_BITS;
    localparam logic [63:0] c_step_mul   = 64'(STEP_MUL);
    localparam freq_q20_t   c_start_q20  = c_start_w[31:0];
    localparam freq_q20_t   c_upper_q20  = c_upper_w[31:0];
    localparam logic [c_div_width-1:0] c_dividend = c_dividend_w[c_div_width-1:0];

    // Period published out of reset, matching what the divider would produce.
    localparam logic [63:0] c_init_wl_w  = (c_start_w == 64'd0) ? 64'hFFFF_FFFF
                                                                : (c_dividend_w / c_start_w);
    localparam logic [31:0] c_init_wl    = (c_init_wl_w > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF
                                                                         : c_init_wl_w[31:0];

    localparam int c_cnt_w = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STEP_SAMPLES - 1);

    sweep_state_t       state_q,    state_d;
    logic               scale_ph_q, scale_ph_d;   // SCALE takes two cycles: multiply, then compare/load
    freq_q20_t          prod_q,     prod_d;
    freq_q20_t          freq_q,     freq_d;
    logic [31:0]        wl_q,       wl_d;
    logic [c_cnt_w-1:0] cnt_q,      cnt_d;
    logic               pend_q,     pend_d;

    logic               tick_en;
    logic               step_ev;
    freq_q20_t          scaled;
    logic               div_start;
    logic               div_done;
    logic [31:0]        div_quotient;

    always_comb begin
        tick_en = sample_tick && enable && !restart;
        step_ev = tick_en && (cnt_q == '0);
        scaled  = 32'((64'(freq_q) * c_step_mul) >> c_q16_shift);

        state_d    = state_q;
        scale_ph_d = scale_ph_q;
        prod_d     = prod_q;
        freq_d     = freq_q;
        wl_d       = wl_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        div_start  = 1'b0;

        if (tick_en) begin
            cnt_d = (cnt_q == c_cnt_last) ? '0 : cnt_q + 1'b1;
        end

        // Steps that arrive while an update is running collapse into one.
        if (step_ev && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (step_ev || pend_q) begin
                    state_d    = ST_SCALE;
                    scale_ph_d = 1'b0;
                    pend_d     = 1'b0;
                end
            end
            ST_SCALE: begin
                if (!scale_ph_q) begin
                    prod_d     = scaled;
                    scale_ph_d = 1'b1;
                end else begin
                    freq_d     = (prod_q >= c_upper_q20) ? c_start_q20 : prod_q;
                    div_start  = 1'b1;
                    scale_ph_d = 1'b0;
                    state_d    = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    wl_d    = div_quotient;
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restart overrides everything above, including a divide finishing
        // in this very cycle, so an aborted result is never published.
        if (restart) begin
            state_d    = ST_DIVIDE;
            scale_ph_d = 1'b0;
            freq_d     = c_start_q20;
            wl_d       = wl_q;
            cnt_d      = '0;
            pend_d     = 1'b0;
            div_start  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scale_ph_q <= 1'b0;
            prod_q     <= '0;
            freq_q     <= c_start_q20;
            wl_q       <= c_init_wl;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scale_ph_q <= scale_ph_d;
            prod_q     <= prod_d;
            freq_q     <= freq_d;
            wl_q       <= wl_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
        end
    end

    // Divisor is the frequency being registered this cycle, so the divide
    // starts in the same cycle the new frequency is loaded. A restart both
    // aborts and reloads; the reload takes precedence inside the divider.
    sweep_divider u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (restart),
        .dividend (c_dividend),
        .divisor  (freq_d),
        .done     (div_done),
        .quotient (div_quotient)
    );

`ifdef SWEEP_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q | (step_ev && pend_q);
        if (restart) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign frequency         = freq_q;
    assign wave_length       = wl_q;
    assign wave_length_valid = (state_q == ST_PUBLISH);
    assign busy              = (state_q != ST_IDLE);

endmodule : sweep_sequencer
`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sweep_sequencer
//  Description : Self-checking bench for sweep_sequencer. Instance A uses
//                default parameters; instance B uses STEP_SAMPLES=1 to
//                exercise step coalescing. Expected wave_length updates are
//                queued when a step or restart is driven and popped when the
//                DUT pulses wave_length_valid.
//  Macro       : SWEEP_OVERRUN_EN - also checks the overrun output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_sequencer;

    localparam logic [31:0] c_start = 32'd57671680;

    typedef struct {
        int          n_ticks;
        int          gap;
        logic        en;
        logic [31:0] exp_freq;
        logic [31:0] exp_wl;
    } vec_t;

    typedef struct {
        logic [31:0] wl;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_tick, a_en, a_restart;
    logic        b_tick, b_restart;
    logic [31:0] a_freq, a_wl, b_freq, b_wl;
    logic        a_valid, a_busy, b_valid, b_busy;
`ifdef SWEEP_OVERRUN_EN
    logic        a_ovr, b_ovr;
`endif

    always #5 clk = ~clk;

    sweep_sequencer u_dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .sample_tick       (a_tick),
        .enable            (a_en),
        .restart           (a_restart),
        .frequency         (a_freq),
        .wave_length       (a_wl),
        .wave_length_valid (a_valid),
`ifdef SWEEP_OVERRUN_EN
        .overrun           (a_ovr),
`endif
        .busy              (a_busy)
    );

    sweep_sequencer #(.STEP_SAMPLES(1)) u_dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .sample_tick       (b_tick),
        .enable            (1'b1),
        .restart           (b_restart),
        .frequency         (b_freq),
        .wave_length       (b_wl),
        .wave_length_valid (b_valid),
`ifdef SWEEP_OVERRUN_EN
        .overrun           (b_ovr),
`endif
        .busy              (b_busy)
    );

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   b_pulses = 0;
    exp_t sb[$];
    logic [31:0] m_freq;
    int   m_cnt;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (b_valid) b_pulses <= b_pulses + 1;

    function automatic logic [31:0] m_next(input logic [31:0] f);
        logic [63:0] p;
        p = ({32'd0, f} * 64'd66191) >> 16;
        if (p[31:0] >= 32'd1048576000) return c_start;
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_wl(input logic [31:0] f);
        logic [63:0] q;
        if (f == 32'd0) return 32'hFFFF_FFFF;
        q = 64'd50331648000 / {32'd0, f};
        if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest queued update, and
    // no queued update may pass its due cycle unpublished.
    always @(negedge clk) begin
        exp_t e;
        if (a_valid) begin
            if (sb.size() == 0) begin
                check("stale_valid", a_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("pub_value", a_wl, e.wl);
                check("pub_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            check("pub_missing", a_valid, 1'b1);
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; the tick belongs to the current cycle.
    task automatic tick_a(input logic en);
        exp_t e;
        a_tick = 1'b1;
        a_en   = en;
        if (en) begin
            if (m_cnt == 0) begin
                m_freq = m_next(m_freq);
                e.wl   = m_wl(m_freq);
                e.due  = cyc + 51;
                sb.push_back(e);
            end
            m_cnt = (m_cnt + 1) % 50;
        end
        @(negedge clk);
        a_tick = 1'b0;
        a_en   = 1'b1;
    endtask

    task automatic restart_a();
        exp_t e;
        a_restart = 1'b1;
        sb.delete();
        m_freq = c_start;
        m_cnt  = 0;
        e.wl   = m_wl(c_start);
        e.due  = cyc + 49;
        sb.push_back(e);
        @(negedge clk);
        a_restart = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[5];
        int          n, r, k_model, steps, b_base;
        logic [31:0] f, f2, f3;

        rst_n = 1'b0; a_tick = 1'b0; a_en = 1'b1; a_restart = 1'b0;
        b_tick = 1'b0; b_restart = 1'b0;
        m_freq = c_start; m_cnt = 0;

        f2 = m_next(32'd58248080);
        f3 = m_next(f2);
        vt[0] = '{49, 2,  1'b1, 32'd58248080, 32'd864};
        vt[1] = '{1,  60, 1'b1, f2,           m_wl(f2)};
        vt[2] = '{50, 2,  1'b0, f2,           m_wl(f2)};
        vt[3] = '{49, 2,  1'b1, f2,           m_wl(f2)};
        vt[4] = '{1,  60, 1'b1, f3,           m_wl(f3)};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_freq",  a_freq,  c_start);
        check("rst_wl",    a_wl,    32'd872);
        check("rst_valid", a_valid, 1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_busy_b", b_busy, 1'b0);
`ifdef SWEEP_OVERRUN_EN
        check("rst_ovr", a_ovr, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // First step: exact latencies
        n = cyc;
        check("busy_before", a_busy, 1'b0);
        tick_a(1'b1);
        check("busy_rise", a_busy, 1'b1);
        at_cycle(n + 2);  check("freq_hold",   a_freq, c_start);
        at_cycle(n + 3);  check("freq_step1",  a_freq, 32'd58248080);
        at_cycle(n + 50); check("wl_prepub",   a_wl,   32'd872);
        at_cycle(n + 51); check("wl_pub1",     a_wl,   32'd864);
        check("valid_pub1", a_valid, 1'b1);
        at_cycle(n + 52); check("busy_fall",   a_busy, 1'b0);
        check("valid_fall", a_valid, 1'b0);

        // Table: counter spacing, enable gating, second and third steps
        for (int i = 0; i < 5; i++) begin
            for (int t = 0; t < vt[i].n_ticks; t++) begin
                tick_a(vt[i].en);
                repeat (vt[i].gap - 1) @(negedge clk);
            end
            repeat (60) @(negedge clk);
            check($sformatf("vec%0d_freq", i), a_freq, vt[i].exp_freq);
            check($sformatf("vec%0d_wl", i),   a_wl,   vt[i].exp_wl);
        end

        // Restart in DIVIDE cycle 20
        restart_a();
        repeat (60) @(negedge clk);
        check("rs0_freq", a_freq, c_start);
        check("rs0_wl",   a_wl,   32'd872);
        n = cyc;
        tick_a(1'b1);
        at_cycle(n + 22);
        check("rs_busy_div", a_busy, 1'b1);
        r = cyc;
        restart_a();
        check("rs_freq", a_freq, c_start);
        at_cycle(r + 60);
        check("rs_wl", a_wl, 32'd872);
        check("rs_idle", a_busy, 1'b0);
        // Counter cleared: the next tick is a step
        n = cyc;
        tick_a(1'b1);
        at_cycle(n + 3);
        check("rs_cnt_clear", a_freq, 32'd58248080);
        at_cycle(n + 60);

        // Sweep to the wrap point
        k_model = 0;
        f = c_start;
        for (int s = 0; s < 1000; s++) begin
            f = m_next(f);
            k_model++;
            if (f == c_start) break;
        end
        restart_a();
        repeat (60) @(negedge clk);
        steps = 0;
        for (int s = 1; s <= 400; s++) begin
            n = cyc;
            repeat (50) tick_a(1'b1);
            at_cycle(n + 60);
            steps = s;
            check("sweep_freq", a_freq, m_freq);
            if (a_freq == c_start) break;
        end
        check("wrap_step", steps, k_model);
        check("wrap_wl",   a_wl,  32'd872);

        // Reset mid-divide
        n = cyc;
        tick_a(1'b1);
        at_cycle(n + 25);
        rst_n = 1'b0;
        sb.delete();
        m_freq = c_start;
        m_cnt  = 0;
        #1;
        check("mrst_freq", a_freq, c_start);
        check("mrst_wl",   a_wl,   32'd872);
        check("mrst_busy", a_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        at_cycle(n + 70);
        check("mrst_wl_after", a_wl, 32'd872);

        // Coalescing with STEP_SAMPLES=1: five back-to-back ticks give two updates
        @(negedge clk);
        b_base = b_pulses;
        n = cyc;
        b_tick = 1'b1;
        repeat (5) @(negedge clk);
        b_tick = 1'b0;
        check("b_busy", b_busy, 1'b1);
`ifdef SWEEP_OVERRUN_EN
        check("b_ovr_set", b_ovr, 1'b1);
`endif
        at_cycle(n + 130);
        check("b_pulses", b_pulses - b_base, 2);
        check("b_freq",   b_freq, m_next(m_next(c_start)));
        check("b_wl",     b_wl,   m_wl(m_next(m_next(c_start))));
        check("b_idle",   b_busy, 1'b0);
`ifdef SWEEP_OVERRUN_EN
        check("b_ovr_hold", b_ovr, 1'b1);
`endif
        b_restart = 1'b1;
        @(negedge clk);
        b_restart = 1'b0;
`ifdef SWEEP_OVERRUN_EN
        check("b_ovr_clear", b_ovr, 1'b0);
`endif
        check("b_rs_freq", b_freq, c_start);
        repeat (60) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sweep_sequencer
`default_nettype wire
